divider_share_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one streamlined_divider_4bit between N_REQ requesters. It accepts per-requester divide requests and drives the divider's start_sig/dong_sig handshake for the granted requester. It returns quotient/reminder plus a one-cycle done pulse to that requester. It also short-circuits divide-by-zero and aborts hung operations on timeout.

---
 rtl/divider_share_arbiter.sv | 131 +++++++++++++
 tb/tb_divider_share_arbiter.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/divider_share_arbiter.sv
// Round-robin front end that time-shares one 4-bit divider between N_REQ requesters,
// short-circuiting divide-by-zero and aborting operations the divider never finishes.
module divider_share_arbiter #(
   parameter int unsigned N_REQ   = 4,
   parameter int unsigned WIDTH   = 4,
   parameter int unsigned TIMEOUT = 31
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [N_REQ-1:0]         req,
   input  logic [N_REQ*WIDTH-1:0]   req_dividend,
   input  logic [N_REQ*WIDTH-1:0]   req_divisor,
   output logic [N_REQ-1:0]         done,
   output logic                     err,
   output logic [WIDTH-1:0]         quotient,
   output logic [WIDTH-1:0]         reminder,
   output logic                     busy,
   output logic                     div_start_sig,
   output logic [WIDTH-1:0]         div_dividend,
   output logic [WIDTH-1:0]         div_divisor,
   input  logic                     div_dong_sig,
   input  logic [WIDTH-1:0]         div_quotient,
   input  logic [WIDTH-1:0]         div_reminder
);

   localparam int unsigned IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int unsigned CW = 8;
   localparam logic [CW-1:0] TO_LIM = CW'(TIMEOUT);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t          r_state;
   logic [IW-1:0]   r_rr;
   logic [IW-1:0]   r_grant;
   logic [CW-1:0]   r_cnt;
   logic            r_zero;

   logic [IW-1:0]   w_grant;
   logic [IW-1:0]   w_cand;
   logic            w_any;
   logic [WIDTH-1:0] w_dvd;
   logic [WIDTH-1:0] w_dvs;

   // First requester at or above the rr pointer, wrapping; lowest offset wins.
   always_comb begin
      w_grant = '0;
      w_cand  = '0;
      w_any   = |req;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         w_cand = IW'((32'(r_rr) + 32'(i)) % N_REQ);
         if (req[w_cand]) w_grant = w_cand;
      end
   end

   assign w_dvd = req_dividend[32'(w_grant) * WIDTH +: WIDTH];
   assign w_dvs = req_divisor[32'(w_grant) * WIDTH +: WIDTH];

   // Divide-by-zero spends one cycle in ISSUE with the divider left idle, then reports.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state       <= S_IDLE;
         r_rr          <= '0;
         r_grant       <= '0;
         r_cnt         <= '0;
         r_zero        <= 1'b0;
         done          <= '0;
         err           <= 1'b0;
         quotient      <= '0;
         reminder      <= '0;
         busy          <= 1'b0;
         div_start_sig <= 1'b0;
         div_dividend  <= '0;
         div_divisor   <= '0;
      end else begin
         done <= '0;
         err  <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_any) begin
                  r_grant      <= w_grant;
                  div_dividend <= w_dvd;
                  div_divisor  <= w_dvs;
                  busy         <= 1'b1;
                  r_cnt        <= '0;
                  r_state      <= S_ISSUE;
                  r_zero       <= (w_dvs == '0);
                  div_start_sig <= (w_dvs != '0);
               end
            end
            S_ISSUE: begin
               if (r_zero) begin
                  r_state     <= S_DONE;
                  done[r_grant] <= 1'b1;
                  err         <= 1'b1;
                  quotient    <= '1;
                  reminder    <= div_dividend;
               end else if (div_dong_sig) begin
                  r_state       <= S_DONE;
                  div_start_sig <= 1'b0;
                  done[r_grant] <= 1'b1;
                  err           <= 1'b0;
                  quotient      <= div_quotient;
                  reminder      <= div_reminder;
               end else if ((r_cnt + CW'(1)) == TO_LIM) begin
                  r_state       <= S_DONE;
                  div_start_sig <= 1'b0;
                  done[r_grant] <= 1'b1;
                  err           <= 1'b1;
                  quotient      <= '0;
                  reminder      <= '0;
               end else begin
                  r_cnt <= r_cnt + CW'(1);
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
               busy    <= 1'b0;
               r_cnt   <= '0;
               r_zero  <= 1'b0;
               r_rr    <= (32'(r_grant) == N_REQ - 1) ? '0 : r_grant + IW'(1);
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_divider_share_arbiter.sv
// Bench for divider_share_arbiter: behavioural divider stub plus a round-robin
// reference that predicts each winner and its result from plain arithmetic.
module tb_divider_share_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  req;
   logic [15:0] dvd;
   logic [15:0] dvs;
   logic [3:0]  done;
   logic        err;
   logic [3:0]  quotient;
   logic [3:0]  reminder;
   logic        busy;
   logic        div_start_sig;
   logic [3:0]  div_dividend;
   logic [3:0]  div_divisor;
   logic        dong;
   logic [3:0]  dq = 4'd0;
   logic [3:0]  dr = 4'd0;

   int total = 0;
   int bad   = 0;
   int rr_m  = 0;
   int lat   = 2;
   int mcnt  = 0;
   bit hang  = 1'b0;

   always #5 clk = ~clk;

   divider_share_arbiter #(.N_REQ(4), .WIDTH(4), .TIMEOUT(31)) dut (
      .clk(clk), .rst_n(rst_n), .req(req),
      .req_dividend(dvd), .req_divisor(dvs),
      .done(done), .err(err), .quotient(quotient), .reminder(reminder),
      .busy(busy), .div_start_sig(div_start_sig),
      .div_dividend(div_dividend), .div_divisor(div_divisor),
      .div_dong_sig(dong), .div_quotient(dq), .div_reminder(dr)
   );

   // Divider stub: answers lat+1 cycles after seeing start, unless hung.
   always @(posedge clk) begin
      if (!rst_n) begin
         dong <= 1'b0;
         mcnt <= 0;
      end else begin
         dong <= 1'b0;
         if (div_start_sig && !dong && !hang) begin
            if (mcnt >= lat) begin
               dong <= 1'b1;
               dq   <= div_dividend / div_divisor;
               dr   <= div_dividend % div_divisor;
               mcnt <= 0;
            end else begin
               mcnt <= mcnt + 1;
            end
         end else if (!div_start_sig) begin
            mcnt <= 0;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int pick(input logic [3:0] r, input int p);
      for (int k = 0; k < 4; k++) if (r[(p + k) % 4]) return (p + k) % 4;
      return 0;
   endfunction

   task automatic set_op(input int i, input int a, input int b);
      dvd[i*4 +: 4] = 4'(a);
      dvs[i*4 +: 4] = 4'(b);
   endtask

   // Predict the next winner, wait for its done pulse, compare against arithmetic.
   task automatic expect_next(input string tag, input bit drop, input bit mutate);
      int w;
      logic [3:0] a, b, eq, er;
      logic ee;
      bit got, seen_idle, mutated, prev_dong;
      w  = pick(req, rr_m);
      a  = dvd[w*4 +: 4];
      b  = dvs[w*4 +: 4];
      eq = (b == 0) ? 4'hF : a / b;
      er = (b == 0) ? a : a % b;
      ee = (b == 0);
      got = 1'b0; mutated = 1'b0; prev_dong = 1'b0;
      seen_idle = !busy;
      for (int n = 0; n < 100 && !got; n++) begin
         prev_dong = dong;
         tick();
         if (|done) got = 1'b1;
         else if (!busy) seen_idle = 1'b1;
         else if (mutate && seen_idle && !mutated) begin
            mutated = 1'b1;
            dvd[w*4 +: 4] = 4'($urandom);
            dvs[w*4 +: 4] = 4'($urandom);
            req[w] = 1'b0;
         end
      end
      chk({tag, "_seen"}, 32'(got), 32'd1);
      if (got) begin
         chk({tag, "_done"}, 32'(done), 32'(1 << w));
         chk({tag, "_q"}, 32'(quotient), 32'(eq));
         chk({tag, "_r"}, 32'(reminder), 32'(er));
         chk({tag, "_err"}, 32'(err), 32'(ee));
         if (b != 0) chk({tag, "_lat"}, 32'(prev_dong), 32'd1);
      end
      if (drop) req[w] = 1'b0;
      rr_m = (w + 1) % 4;
   endtask

   initial begin
      int cnt;
      bit got;
      rst_n = 1'b0; req = '0; dvd = '0; dvs = '0;
      tick(); tick(); tick();
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      chk("rst_q", 32'(quotient), 32'd0);
      chk("rst_r", 32'(reminder), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_start", 32'(div_start_sig), 32'd0);
      chk("rst_dvd", 32'(div_dividend), 32'd0);
      chk("rst_dvs", 32'(div_divisor), 32'd0);
      rst_n = 1'b1;
      tick();

      // single request 7/2
      set_op(0, 7, 2); req = 4'b0001;
      tick();
      chk("t1_start", 32'(div_start_sig), 32'd1);
      chk("t1_dvd", 32'(div_dividend), 32'd7);
      chk("t1_dvs", 32'(div_divisor), 32'd2);
      chk("t1_busy", 32'(busy), 32'd1);
      expect_next("t1", 1'b1, 1'b0);

      // two simultaneous requests, one idle gap between them
      set_op(1, 9, 4); set_op(3, 15, 3); req = 4'b1010;
      expect_next("t2a", 1'b1, 1'b0);
      tick();
      chk("t2_gap_start", 32'(div_start_sig), 32'd0);
      chk("t2_gap_busy", 32'(busy), 32'd0);
      expect_next("t2b", 1'b1, 1'b0);

      // divide by zero
      tick();
      set_op(2, 6, 0); req = 4'b0100;
      tick();
      chk("t3_start", 32'(div_start_sig), 32'd0);
      chk("t3_early", 32'(done), 32'd0);
      tick();
      chk("t3_done", 32'(done), 32'b0100);
      chk("t3_q", 32'(quotient), 32'hF);
      chk("t3_r", 32'(reminder), 32'd6);
      chk("t3_err", 32'(err), 32'd1);
      chk("t3_start2", 32'(div_start_sig), 32'd0);
      req = '0; rr_m = 3;

      // hung divider -> timeout
      tick();
      hang = 1'b1;
      set_op(3, 5, 1); req = 4'b1000;
      cnt = 0; got = 1'b0;
      for (int n = 0; n < 100 && !got; n++) begin
         tick();
         if (div_start_sig) cnt++;
         if (|done) got = 1'b1;
      end
      chk("t4_seen", 32'(got), 32'd1);
      chk("t4_cycles", 32'(cnt), 32'd31);
      chk("t4_done", 32'(done), 32'b1000);
      chk("t4_err", 32'(err), 32'd1);
      chk("t4_q", 32'(quotient), 32'd0);
      chk("t4_r", 32'(reminder), 32'd0);
      req = '0; rr_m = 0; hang = 1'b0;
      set_op(0, 13, 4); req = 4'b0001;
      expect_next("t4n", 1'b1, 1'b0);

      // reset during ISSUE
      tick();
      lat = 6;
      set_op(1, 8, 3); req = 4'b0010;
      tick();
      chk("t5_start", 32'(div_start_sig), 32'd1);
      tick();
      rst_n = 1'b0;
      tick();
      chk("t5_start_rst", 32'(div_start_sig), 32'd0);
      chk("t5_busy_rst", 32'(busy), 32'd0);
      chk("t5_done_rst", 32'(done), 32'd0);
      rst_n = 1'b1; rr_m = 0; lat = 2;
      set_op(0, 8, 3); set_op(1, 12, 5); req = 4'b0011;
      expect_next("t5a", 1'b1, 1'b0);
      expect_next("t5b", 1'b1, 1'b0);

      // all requesters held high continuously
      tick();
      rst_n = 1'b0; tick(); rst_n = 1'b1; rr_m = 0;
      for (int i = 0; i < 4; i++) set_op(i, $urandom_range(0, 15), $urandom_range(1, 15));
      req = 4'b1111;
      for (int k = 0; k < 5; k++) expect_next("all", 1'b0, 1'b0);
      req = '0;
      tick(); tick();

      // randomized masks, operands, latencies, withdrawal and operand churn
      for (int t = 0; t < 24; t++) begin
         if (req == 4'b0000) begin
            req = 4'($urandom_range(1, 15));
            for (int i = 0; i < 4; i++)
               set_op(i, $urandom_range(0, 15),
                      ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, 15));
         end
         lat = $urandom_range(0, 4);
         expect_next("rnd", 1'b1, t[0]);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
